// File: rtl/pid_err_gen.sv
// Error front-end for the PID loop: saturated, deadbanded setpoint-feedback error,
// a two-deep error history, and a clamped anti-windup integral.
module pid_err_gen #(
    parameter logic signed [31:0] INT_MAX  = 32'sd1000000,
    parameter logic signed [31:0] INT_MIN  = -32'sd1000000,
    parameter logic        [31:0] DEADBAND = 32'd0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sample_en,
    input  logic signed [31:0] setpoint,
    input  logic signed [31:0] feedback,
    input  logic               int_clr,
    input  logic               int_hold,
    input  logic               restart,
    output logic signed [31:0] error,
    output logic signed [31:0] error1,
    output logic signed [31:0] sum_e,
    output logic               err_valid,
    output logic               primed
);

    typedef enum logic {EMPTY, RUN} state_t;

    function automatic logic signed [31:0] sat_diff(input logic signed [32:0] d);
        if (d > 33'sh0_7FFF_FFFF)
            return 32'sh7FFF_FFFF;
        else if (d < -33'sh0_8000_0000)
            return 32'sh8000_0000;
        else
            return d[31:0];
    endfunction

    // -2^31 has magnitude 2^31, which the unsigned 32-bit two's complement yields.
    function automatic logic signed [31:0] deadband(input logic signed [31:0] x);
        logic [31:0] mag;
        mag = x[31] ? (~x + 32'd1) : x;
        if (mag <= DEADBAND)
            return 32'sd0;
        else
            return x;
    endfunction

    function automatic logic signed [31:0] clamp_int(input logic signed [32:0] s);
        if (s > $signed({INT_MAX[31], INT_MAX}))
            return INT_MAX;
        else if (s < $signed({INT_MIN[31], INT_MIN}))
            return INT_MIN;
        else
            return s[31:0];
    endfunction

    logic signed [32:0] diff;
    logic signed [31:0] e_new_q;
    logic               s1_vld_q;

    logic signed [31:0] error_q, error1_q, sum_e_q;
    logic               err_valid_q, primed_q;
    state_t             state_q;

    logic signed [32:0] sum_ext;
    logic               integrate;

    assign diff = {setpoint[31], setpoint} - {feedback[31], feedback};

    // Stage 1: capture the conditioned error
    always_ff @(posedge clk) begin
        if (sample_en)
            e_new_q <= deadband(sat_diff(diff));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            s1_vld_q <= 1'b0;
        else
            s1_vld_q <= sample_en && !restart;
    end

    // Under hold, only integrate when the new error pulls the integral back toward zero.
    assign sum_ext   = {sum_e_q[31], sum_e_q} + {e_new_q[31], e_new_q};
    assign integrate = !int_hold ||
                       ((e_new_q != 32'sd0) && (sum_e_q != 32'sd0) && (e_new_q[31] != sum_e_q[31]));

    // Stage 2: commit into history and integral
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            error_q     <= 32'sd0;
            error1_q    <= 32'sd0;
            sum_e_q     <= 32'sd0;
            err_valid_q <= 1'b0;
            primed_q    <= 1'b0;
            state_q     <= EMPTY;
        end else begin
            err_valid_q <= 1'b0;
            if (restart) begin
                state_q  <= EMPTY;
                primed_q <= 1'b0;
            end else if (s1_vld_q) begin
                case (state_q)
                    EMPTY: begin
                        error_q  <= e_new_q;
                        error1_q <= e_new_q;
                    end
                    default: begin
                        error_q  <= e_new_q;
                        error1_q <= error_q;
                    end
                endcase
                if (integrate)
                    sum_e_q <= clamp_int(sum_ext);
                state_q     <= RUN;
                primed_q    <= 1'b1;
                err_valid_q <= 1'b1;
            end
            if (int_clr)
                sum_e_q <= 32'sd0;
        end
    end

    assign error     = error_q;
    assign error1    = error1_q;
    assign sum_e     = sum_e_q;
    assign err_valid = err_valid_q;
    assign primed    = primed_q;

endmodule
